// File: rtl/iq_cic_decimator.sv
// Dual-channel (I/Q) CIC decimator: STAGES integrators running at the input
// rate, a shared sample counter that marks every DECIM-th accepted sample,
// STAGES comb stages at the decimated rate, then round-half-to-even and
// saturation down to OUT_W bits.
//
// Handshake: in_valid qualifies in_i/in_q for one cycle and is always
// accepted (no ready). out_valid is a one-cycle pulse that qualifies
// out_i/out_q. It is registered two edges after the edge that accepted the
// tick sample. out_i/out_q hold their value between pulses.
//
// Output timeline for a tick sample accepted at edge t:
//   edge t   : the new integrator output is captured into samp_q, tick1_q set
//   edge t+1 : comb chain evaluated from samp_q into comb_q, tick2_q set
//   edge t+2 : rounded/saturated result loaded into res_q, out_valid high
//
// Assumes OUT_W < ACC_W so that at least one bit is rounded away.
module iq_cic_decimator #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int STAGES = 3,
  parameter int DECIM  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_i,
  input  logic signed [IN_W-1:0]  in_q,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q,
  output logic                    sat
);

  localparam int CNT_W = $clog2(DECIM);
  localparam int ACC_W = IN_W + STAGES * CNT_W;
  localparam int SH    = ACC_W - OUT_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [SH-1:0]    HALF     = SH'(1) << (SH - 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // Index 0 is the I channel, index 1 is the Q channel.
  logic signed [ACC_W-1:0] integ_q [2][STAGES];
  logic signed [ACC_W-1:0] integ_d [2][STAGES];
  logic signed [ACC_W-1:0] samp_q  [2];
  logic signed [ACC_W-1:0] samp_d  [2];
  logic signed [ACC_W-1:0] dly_q   [2][STAGES];
  logic signed [ACC_W-1:0] dly_d   [2][STAGES];
  logic signed [ACC_W-1:0] comb_q  [2];
  logic signed [ACC_W-1:0] comb_d  [2];
  logic signed [OUT_W-1:0] res_q   [2];
  logic signed [OUT_W-1:0] res_d   [2];

  logic tick1_q, tick2_q, valid_q, sat_q, sat_d;

  logic signed [IN_W-1:0]  x_in;
  logic signed [ACC_W-1:0] int_acc;
  logic signed [ACC_W-1:0] comb_acc;
  logic signed [OUT_W-1:0] keep;
  logic        [SH-1:0]    frac;
  logic                    rnd_up;
  logic signed [OUT_W:0]   rnd;

  // Shared sample counter; the last count slot of an accepted sample is the tick.
  always_comb begin
    tick  = in_valid && (cnt_q == CNT_LAST);
    cnt_d = in_valid ? cnt_q + 1'b1 : cnt_q;
  end

  // Integrator ripple: every stage updates in the cycle the sample is accepted.
  always_comb begin
    integ_d = integ_q;
    samp_d  = samp_q;
    x_in    = '0;
    int_acc = '0;
    if (in_valid) begin
      for (int ch = 0; ch < 2; ch++) begin
        x_in    = (ch == 0) ? in_i : in_q;
        int_acc = {{(ACC_W-IN_W){x_in[IN_W-1]}}, x_in};
        for (int k = 0; k < STAGES; k++) begin
          int_acc        = integ_q[ch][k] + int_acc;
          integ_d[ch][k] = int_acc;
        end
        if (tick) samp_d[ch] = int_acc;
      end
    end
  end

  // Comb chain at the decimated rate, differential delay of one output sample.
  always_comb begin
    dly_d    = dly_q;
    comb_d   = comb_q;
    comb_acc = '0;
    if (tick1_q) begin
      for (int ch = 0; ch < 2; ch++) begin
        comb_acc = samp_q[ch];
        for (int k = 0; k < STAGES; k++) begin
          dly_d[ch][k] = comb_acc;
          comb_acc     = comb_acc - dly_q[ch][k];
        end
        comb_d[ch] = comb_acc;
      end
    end
  end

  // Round half to even on the dropped bits, then clamp to the OUT_W range.
  always_comb begin
    res_d  = res_q;
    sat_d  = sat_q;
    keep   = '0;
    frac   = '0;
    rnd_up = 1'b0;
    rnd    = '0;
    if (tick2_q) begin
      for (int ch = 0; ch < 2; ch++) begin
        keep   = comb_q[ch][ACC_W-1:SH];
        frac   = comb_q[ch][SH-1:0];
        rnd_up = (frac > HALF) || ((frac == HALF) && keep[0]);
        rnd    = {keep[OUT_W-1], keep} + (OUT_W+1)'(rnd_up);
        if (rnd[OUT_W] != rnd[OUT_W-1]) begin
          res_d[ch] = rnd[OUT_W] ? OUT_MIN : OUT_MAX;
          sat_d     = 1'b1;
        end else begin
          res_d[ch] = rnd[OUT_W-1:0];
        end
      end
    end
  end

  // State registers; reset clears everything, including in-flight ticks.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q   <= '0;
      tick1_q <= 1'b0;
      tick2_q <= 1'b0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        samp_q[ch] <= '0;
        comb_q[ch] <= '0;
        res_q[ch]  <= '0;
        for (int k = 0; k < STAGES; k++) begin
          integ_q[ch][k] <= '0;
          dly_q[ch][k]   <= '0;
        end
      end
    end else begin
      cnt_q   <= cnt_d;
      tick1_q <= tick;
      tick2_q <= tick1_q;
      valid_q <= tick2_q;
      sat_q   <= sat_d;
      for (int ch = 0; ch < 2; ch++) begin
        samp_q[ch] <= samp_d[ch];
        comb_q[ch] <= comb_d[ch];
        res_q[ch]  <= res_d[ch];
        for (int k = 0; k < STAGES; k++) begin
          integ_q[ch][k] <= integ_d[ch][k];
          dly_q[ch][k]   <= dly_d[ch][k];
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_i     = res_q[0];
  assign out_q     = res_q[1];
  assign sat       = sat_q;

endmodule

// File: doc/iq_cic_decimator.md
IQ_CIC_DECIMATOR -- requirements
Module: iq_cic_decimator

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, meaning signed I and Q input sample width.
REQ-002 The block SHALL have parameter OUT_W, default 16, meaning signed I and Q output sample width.
REQ-003 The block SHALL have parameter STAGES, default 3, meaning number of integrator stages and number of comb stages.
REQ-004 The block SHALL have parameter DECIM, default 16, meaning decimation ratio; it SHALL be a power of two, 2..256.
REQ-005 The block SHALL have localparam ACC_W = IN_W + STAGES*log2(DECIM), default 28.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, the 32 MHz receiver clock; all logic on its rising edge.
REQ-007 The block SHALL have port resetn, input, 1 bit: the synchronous, active-low reset.
REQ-008 The block SHALL have port in_valid, input, 1 bit: an input sample is present this cycle (the mixer output valid).
REQ-009 The block SHALL have port in_i, input, IN_W bits, signed: in-phase mixer output.
REQ-010 The block SHALL have port in_q, input, IN_W bits, signed: quadrature mixer output.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a single-cycle pulse that qualifies out_i and out_q.
REQ-012 The block SHALL have port out_i, output, OUT_W bits, signed: decimated in-phase baseband.
REQ-013 The block SHALL have port out_q, output, OUT_W bits, signed: decimated quadrature baseband.
REQ-014 The block SHALL have port sat, output, 1 bit: a sticky flag that is set when either output was saturated.

Function
REQ-015 The block SHALL process I and Q through identical, independent channels that share one sample counter.
REQ-016 A sample SHALL be accepted on every cycle with in_valid=1; no backpressure SHALL exist, and cycles with in_valid=0 SHALL leave all state unchanged.
REQ-017 On acceptance the integrators SHALL ripple in the same cycle, sign-extending x to ACC_W: int1' = int1 + x, intk' = intk + int(k-1)' for k=2..STAGES.
REQ-018 All integrator and comb arithmetic SHALL be ACC_W-bit two's complement with silent wrap-around, and wrap SHALL NOT be flagged.
REQ-019 The sample counter SHALL run 0..DECIM-1, increment on each acceptance, and wrap to 0 after DECIM-1.
REQ-020 An acceptance with counter = DECIM-1 SHALL be a decimation tick.
REQ-021 On a decimation tick the comb section SHALL register, one cycle later, c0 = intSTAGES', ck = c(k-1) - dk, with dk <= c(k-1) for k=1..STAGES (differential delay 1).
REQ-022 The stage after the comb SHALL round c_STAGES to OUT_W by dropping the low ACC_W-OUT_W bits, round-half-to-even.
REQ-023 After rounding, the result SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-024 Any saturation in either channel SHALL set sat, which SHALL stay set until reset.
REQ-025 Latency SHALL be fixed: out_valid SHALL pulse exactly 2 cycles after the clk edge that accepted the tick sample.
REQ-026 out_valid SHALL pulse for 1 cycle only, and exactly once per DECIM accepted samples.
REQ-027 out_i and out_q SHALL hold their value between pulses.
REQ-028 DC gain SHALL be DECIM^STAGES / 2^(ACC_W-OUT_W) = 1 at the defaults.
REQ-029 A constant input SHALL reproduce exactly on the output from the (STAGES)-th output pulse onward.
REQ-030 A tick SHALL NOT be lost or duplicated when in_valid gaps occur, including a gap immediately before or after the tick sample.

Reset
REQ-031 When resetn=0 on a clk edge, all integrators, comb delays, the comb pipeline, the counter, out_i, out_q, out_valid and sat SHALL be cleared to 0.
REQ-032 When resetn=0, reset SHALL dominate a simultaneous in_valid, and that sample SHALL be discarded.
REQ-033 A reset mid-frame SHALL cancel any in-flight tick: no out_valid SHALL occur in the 2 cycles after reset.
REQ-034 After reset the first out_valid SHALL follow the DECIM-th accepted sample.

Verification
REQ-035 The bench SHALL cover a continuous constant input: in_i=1000, in_q=-1000 on every cycle -> pulses every 16 cycles; 3rd and later pulses out_i=1000, out_q=-1000; sat=0.
REQ-036 The bench SHALL cover full scale: in_i=32767, in_q=-32768 constant -> steady out_i=32767, out_q=-32768, sat=0.
REQ-037 The bench SHALL cover gapped input: in_valid=1 every 3rd cycle, in_i=500 -> pulse 2 cycles after each 16th accepted sample (48-cycle spacing), steady out_i=500.
REQ-038 The bench SHALL cover counter wrap: 160 accepted samples -> exactly 10 out_valid pulses, each 1 cycle wide.
REQ-039 The bench SHALL cover reset mid-frame: assert resetn=0 for 1 cycle on the cycle the 16th sample is accepted -> no pulse follows; all outputs 0; next pulse 2 cycles after 16th post-reset sample.
REQ-040 The bench SHALL cover the integrator wrap run: 10^6 samples at in_i=32767 (integrators wrap repeatedly) -> out_i stays 32767 with no glitch.
